tx_coding_chain: RTL and testbench
==================================

Name: tx_coding_chain

Overview:
- Transmit-side bit-coding chain for the 802.11a baseband; mirror of the receive chain (deinterleave -> Viterbi -> descramble).
- Takes serial payload bits and performs, in order: 7-bit scrambling, rate-1/2 K=7 convolutional encoding, and BPSK block interleaving over 48 coded bits.
- Emits one interleaved coded bit per cycle toward the mapper.
- Self-contained: scrambler, encoder and ping-pong interleaver banks are all inside this block.

Parameters:
SEED, 7'b1011101, scrambler initial state {x7..x1}; 0 disables scrambling (LFSR stays zero, data passes through unchanged).
N_CBPS, 48, coded bits per OFDM symbol; fixed at 48 (BPSK, s=1).

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
En  in  1  block enable; En=0 acts as a synchronous clear identical to Reset
Data  in  1  payload bit
Data_valid  in  1  Data is valid this cycle
Data_ready  out  1  block accepts Data this cycle (combinational)
Out  out  1  interleaved coded bit (registered)
Out_valid  out  1  Out is valid (registered)
Sym_start  out  1  Out is bit 0 of a 48-bit symbol (registered)

Behaviour:
- Reset or ~En on a clock edge clears the following:
  - LFSR is set to SEED; encoder shift register to 0.
  - Input count k=0; write bank wb=0; read bank rb=0.
  - full[1:0]=0; reader goes idle; read index=0.
  - Out=0, Out_valid=0, Sym_start=0.
  - Applies mid-symbol: partial bank contents are discarded and no output is produced for them.
- Data_ready = En & ~Reset & ~full[wb]. A bit is accepted when Data_valid & Data_ready; one bit per cycle maximum.
- Scrambler, on each accept:
  - f = x7 ^ x4; s = Data ^ f.
  - Shift {x7..x1} <= {x6..x1, f}.
- Encoder, on each accept:
  - Let d0=s and d1..d6 = previous scrambled bits.
  - A = d0^d2^d3^d5^d6 (g0=133 octal); B = d0^d1^d2^d3^d6 (g1=171 octal).
  - The shift register then advances.
- Interleaver write:
  - A is coded bit c=2k, B is c=2k+1.
  - Each coded bit is written to bank[wb][i] with i = 3*(c mod 16) + floor(c/16); both bits are written in the same cycle.
  - k counts 0..23. Accepting k=23 sets full[wb], toggles wb and resets k=0, all on the same edge.
- Scrambler and encoder state persist across symbols; they are cleared only by Reset or ~En.
- Reader FSM has two states:
  - IDLE: if full[rb], go to READ with idx=0.
  - READ, each cycle:
    - Out <= bank[rb][idx]; Out_valid <= 1; Sym_start <= (idx==0); idx++.
    - At idx==47: clear full[rb] and toggle rb on that edge.
    - If the other bank is already full, continue READ with idx=0 on the next cycle, so symbols are back-to-back with no bubble. Otherwise go to IDLE; Out_valid=0 and Sym_start=0 on the following cycle.
- Latency: the first Out_valid of a symbol appears on the 2nd rising edge after the edge that accepted its 24th input bit.
- Simultaneous events:
  - The writer setting full on one bank and the reader clearing full on the other bank on the same edge are both honoured.
  - A bank cleared by the reader at idx==47 is writable (Data_ready=1) on the next cycle.
- Throughput:
  - Steady state is limited by the reader: 24 input bits per 48 output cycles.
  - With both banks full, Data_ready=0 until a read completes.

Test Plan:
- SEED=0; single bit 1 then 23 zeros, Data_valid held high -> exactly 48 Out_valid cycles; Sym_start only on the first; Out=1 only at positions {0,3,9,12,15,18,21,30,36,39}.
- SEED=0; 24 zeros -> 48 zero output bits; Out_valid first rises 2 edges after the 24th accept.
- SEED=7'b1011101; 72 zero bits streamed continuously -> Data_ready drops after 48 accepts (both banks full) and recovers one cycle after the first symbol's idx 47. The three symbols are output back-to-back (144 consecutive Out_valid). Bits match the golden model of the scrambler, encoder and interleaver.
- Data_valid toggled 1/0 pseudo-randomly over 48 bits -> identical Out sequence to the continuous-input run. The gap between symbols is 0 or ≥1 idle cycle, consistent with the FSM rules.
- Reset pulse at input bit 10 of the 2nd symbol, while symbol 1 is being read -> next cycle Out_valid=0, Out=0, Data_ready=1. The following 24 bits produce output matching a fresh-SEED golden model.
- En=0 for one cycle mid-stream -> same response as the Reset case. While En=0, Data_ready=0.

Source files
------------

// File: rtl/tx_coding_chain.sv
// 802.11a transmit bit-coding chain: scrambler, rate-1/2 K=7 convolutional
// encoder and a ping-pong BPSK block interleaver emitting one coded bit per cycle.
module tx_coding_chain #(
    parameter logic [6:0] SEED   = 7'b1011101,
    parameter int         N_CBPS = 48
) (
    input  logic Clk,
    input  logic Reset,
    input  logic En,
    input  logic Data,
    input  logic Data_valid,
    output logic Data_ready,
    output logic Out,
    output logic Out_valid,
    output logic Sym_start
);

    localparam logic [4:0] K_LAST   = 5'(N_CBPS / 2 - 1);
    localparam logic [5:0] IDX_LAST = 6'(N_CBPS - 1);

    typedef enum logic {IDLE, READ} state_t;

    logic [6:0]        lfsr_q, lfsr_d;
    logic [5:0]        enc_q, enc_d;
    logic [4:0]        k_q, k_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [1:0]        full_q, full_d;
    state_t            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic              out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              sym_start_q, sym_start_d;
    logic [N_CBPS-1:0] bank0_q, bank0_d;
    logic [N_CBPS-1:0] bank1_q, bank1_d;

    logic       clear;
    logic       accept;
    logic       fb;
    logic       scr;
    logic [6:0] win;
    logic       code_a;
    logic       code_b;
    logic [5:0] idx_a;
    logic [5:0] idx_b;

    assign clear      = Reset | ~En;
    assign Data_ready = En & ~Reset & ~full_q[wb_q];
    assign accept     = Data_valid & Data_ready;

    assign fb  = lfsr_q[6] ^ lfsr_q[3];
    assign scr = Data ^ fb;

    // win[n] is d_n: the current scrambled bit followed by the six previous ones
    assign win    = {enc_q, scr};
    assign code_a = win[0] ^ win[2] ^ win[3] ^ win[5] ^ win[6];
    assign code_b = win[0] ^ win[1] ^ win[2] ^ win[3] ^ win[6];

    // c = 2k, so c mod 16 = {k[2:0],0} and c/16 = k[4:3]; bit c+1 lands 3 slots later
    assign idx_a = ({2'b00, k_q[2:0], 1'b0} * 6'd3) + {4'b0000, k_q[4:3]};
    assign idx_b = idx_a + 6'd3;

    always_comb begin
        lfsr_d      = lfsr_q;
        enc_d       = enc_q;
        k_d         = k_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        full_d      = full_q;
        state_d     = state_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        sym_start_d = sym_start_q;
        bank0_d     = bank0_q;
        bank1_d     = bank1_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                sym_start_d = 1'b0;
                if (full_q[rb_q]) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                out_d       = rb_q ? bank1_q[idx_q] : bank0_q[idx_q];
                out_valid_d = 1'b1;
                sym_start_d = (idx_q == '0);
                if (idx_q == IDX_LAST) begin
                    full_d[rb_q] = 1'b0;
                    rb_d         = ~rb_q;
                    idx_d        = '0;
                    if (!full_q[~rb_q]) begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Writer touches only bank wb, which the reader never owns while it is writable
        if (accept) begin
            lfsr_d = {lfsr_q[5:0], fb};
            enc_d  = win[5:0];
            if (wb_q) begin
                bank1_d[idx_a] = code_a;
                bank1_d[idx_b] = code_b;
            end else begin
                bank0_d[idx_a] = code_a;
                bank0_d[idx_b] = code_b;
            end
            if (k_q == K_LAST) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
                k_d          = '0;
            end else begin
                k_d = k_q + 5'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (clear) begin
            lfsr_q      <= SEED;
            enc_q       <= '0;
            k_q         <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            full_q      <= '0;
            state_q     <= IDLE;
            idx_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sym_start_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            enc_q       <= enc_d;
            k_q         <= k_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            full_q      <= full_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sym_start_q <= sym_start_d;
        end
    end

    // Bank storage needs no reset: stale contents are never read once full is cleared
    always_ff @(posedge Clk) begin
        bank0_q <= bank0_d;
        bank1_q <= bank1_d;
    end

    assign Out       = out_q;
    assign Out_valid = out_valid_q;
    assign Sym_start = sym_start_q;

endmodule

// File: tb/tb_tx_coding_chain.sv
// Scoreboard bench for tx_coding_chain: two instances (SEED=0 and default SEED)
// share one input stream; a bit-level golden model predicts every output symbol.
module tb_tx_coding_chain;

    logic Clk = 1'b0;
    logic Reset;
    logic En;
    logic Data;
    logic Data_valid;
    logic rdy  [2];
    logic outb [2];
    logic ov   [2];
    logic ss   [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [6:0]  m_lfsr [2];
    logic [5:0]  m_hist [2];
    int          m_k    [2];
    logic [47:0] m_bank [2];
    logic [1:0]  exp_q0 [$];
    logic [1:0]  exp_q1 [$];

    int          pos0;
    int          ss_cnt0;
    int          valid_cnt [2];
    int          run_len;
    int          max_run;
    int          first_valid_cyc;
    int          last_accept_cyc;
    logic        prev_ov0;
    logic [47:0] cap0;

    tx_coding_chain #(.SEED(7'b0000000), .N_CBPS(48)) dut0 (
        .Clk(Clk), .Reset(Reset), .En(En), .Data(Data), .Data_valid(Data_valid),
        .Data_ready(rdy[0]), .Out(outb[0]), .Out_valid(ov[0]), .Sym_start(ss[0])
    );

    tx_coding_chain #(.SEED(7'b1011101), .N_CBPS(48)) dut1 (
        .Clk(Clk), .Reset(Reset), .En(En), .Data(Data), .Data_valid(Data_valid),
        .Data_ready(rdy[1]), .Out(outb[1]), .Out_valid(ov[1]), .Sym_start(ss[1])
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] seedOf(input int m);
        return (m == 0) ? 7'b0000000 : 7'b1011101;
    endfunction

    function automatic int ilv(input int c);
        return 3 * (c % 16) + c / 16;
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            m_lfsr[m] = seedOf(m);
            m_hist[m] = '0;
            m_k[m]    = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic modelAccept(input logic d);
        logic f, s, a, b;
        logic [6:0] dv;
        for (int m = 0; m < 2; m++) begin
            f = m_lfsr[m][6] ^ m_lfsr[m][3];
            s = d ^ f;
            m_lfsr[m] = {m_lfsr[m][5:0], f};
            dv = {m_hist[m], s};
            a = dv[0] ^ dv[2] ^ dv[3] ^ dv[5] ^ dv[6];
            b = dv[0] ^ dv[1] ^ dv[2] ^ dv[3] ^ dv[6];
            m_hist[m] = dv[5:0];
            m_bank[m][ilv(2 * m_k[m])]     = a;
            m_bank[m][ilv(2 * m_k[m] + 1)] = b;
            m_k[m]++;
            if (m_k[m] == 24) begin
                for (int p = 0; p < 48; p++) begin
                    if (m == 0) exp_q0.push_back({p == 0, m_bank[m][p]});
                    else        exp_q1.push_back({p == 0, m_bank[m][p]});
                end
                m_k[m] = 0;
            end
        end
    endtask

    function automatic int qSize(input int m);
        return (m == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [1:0] popExp(input int m);
        return (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    // Output side of the scoreboard, sampled mid-cycle
    always @(negedge Clk) begin
        logic [1:0] e;
        for (int m = 0; m < 2; m++) begin
            if (ov[m]) begin
                valid_cnt[m]++;
                if (qSize(m) == 0) begin
                    checkOutput("out_valid_without_symbol", ov[m], 0);
                end else begin
                    e = popExp(m);
                    checkOutput(m == 0 ? "out_bit_seed0" : "out_bit_seed", outb[m], e[0]);
                    checkOutput(m == 0 ? "sym_start_seed0" : "sym_start_seed", ss[m], e[1]);
                end
            end else begin
                checkOutput("sym_start_while_idle", ss[m], 0);
            end
        end
        if (ov[0]) begin
            if (pos0 < 48) cap0[pos0] = outb[0];
            pos0++;
            if (ss[0]) ss_cnt0++;
            if (!prev_ov0 && first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        prev_ov0 = ov[0];
        run_len = ov[1] ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
    end

    task automatic applyStimulus(input logic d, input logic v, input logic rst, input logic en,
                                 output logic acc);
        @(negedge Clk);
        Data       = d;
        Data_valid = v;
        Reset      = rst;
        En         = en;
        #1;
        acc = v & rdy[0] & ~rst & en;
        @(posedge Clk);
        #1;
        if (rst || !en) begin
            modelReset();
        end else if (acc) begin
            modelAccept(d);
            last_accept_cyc = cyc;
        end
    endtask

    task automatic clearStats();
        pos0            = 0;
        ss_cnt0         = 0;
        valid_cnt[0]    = 0;
        valid_cnt[1]    = 0;
        run_len         = 0;
        max_run         = 0;
        first_valid_cyc = -1;
        cap0            = '0;
    endtask

    task automatic doReset();
        logic acc;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, acc);
    endtask

    task automatic sendStream(input int n, input bit rand_data, input bit rand_valid);
        int   got   = 0;
        int   tries = 0;
        logic acc, d, v;
        while (got < n && tries < 4 * n + 200) begin
            d = rand_data  ? 1'($urandom_range(0, 1)) : 1'b0;
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(d, v, 1'b0, 1'b1, acc);
            if (acc) got++;
            tries++;
        end
        checkOutput("accept_count", got, n);
    endtask

    task automatic waitDrain();
        int   w = 0;
        logic acc;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || ov[0] || ov[1]) && w < 500) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);
            w++;
        end
        checkOutput("drain_pending_seed0", exp_q0.size(), 0);
        checkOutput("drain_pending_seed", exp_q1.size(), 0);
        checkOutput("drain_out_valid", ov[1], 0);
    endtask

    task automatic checkCleared(input string tag);
        for (int m = 0; m < 2; m++) begin
            checkOutput({tag, "_out"}, outb[m], 0);
            checkOutput({tag, "_out_valid"}, ov[m], 0);
            checkOutput({tag, "_sym_start"}, ss[m], 0);
        end
    endtask

    initial begin
        logic        acc;
        logic [47:0] impulse;
        int          ones [10] = '{0, 3, 9, 12, 15, 18, 21, 30, 36, 39};
        int          accepted;
        int          low_cnt;
        int          tries;

        Data       = 1'b0;
        Data_valid = 1'b0;
        Reset      = 1'b1;
        En         = 1'b1;
        prev_ov0   = 1'b0;
        clearStats();
        modelReset();

        $display("[TB] reset state");
        doReset();
        checkCleared("reset");
        checkOutput("ready_in_reset", rdy[0], 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);
        checkOutput("ready_after_reset", rdy[0], 1);

        $display("[TB] impulse response, SEED=0");
        clearStats();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, acc);
        checkOutput("impulse_first_accept", acc, 1);
        sendStream(23, 1'b0, 1'b0);
        waitDrain();
        impulse = '0;
        foreach (ones[i]) impulse[ones[i]] = 1'b1;
        checkOutput("impulse_valid_count", valid_cnt[0], 48);
        checkOutput("impulse_sym_start_count", ss_cnt0, 1);
        checkOutput("impulse_pattern_lo", cap0[31:0], impulse[31:0]);
        checkOutput("impulse_pattern_hi", {16'h0, cap0[47:32]}, {16'h0, impulse[47:32]});

        $display("[TB] zero symbol and latency");
        doReset();
        clearStats();
        sendStream(24, 1'b0, 1'b0);
        waitDrain();
        checkOutput("latency_edges", first_valid_cyc - last_accept_cyc, 2);
        checkOutput("zero_valid_count", valid_cnt[0], 48);
        checkOutput("zero_pattern_lo", cap0[31:0], 0);
        checkOutput("zero_pattern_hi", {16'h0, cap0[47:32]}, 0);

        $display("[TB] 72 bits streamed, both banks full");
        doReset();
        clearStats();
        accepted = 0;
        low_cnt  = 0;
        tries    = 0;
        while (accepted < 72 && tries < 1000) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, acc);
            tries++;
            if (acc) accepted++;
            else if (accepted == 48) low_cnt++;
        end
        checkOutput("stream_accepts", accepted, 72);
        checkOutput("ready_low_cycles", low_cnt, 25);
        waitDrain();
        checkOutput("back_to_back_run", max_run, 144);
        checkOutput("stream_valid_count", valid_cnt[1], 144);

        $display("[TB] gapped input");
        doReset();
        clearStats();
        sendStream(48, 1'b1, 1'b1);
        waitDrain();
        checkOutput("gapped_valid_count", valid_cnt[1], 96);

        $display("[TB] reset mid-stream");
        doReset();
        sendStream(34, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, acc);
        checkCleared("midreset");
        Reset      = 1'b0;
        Data_valid = 1'b0;
        #1;
        checkOutput("midreset_ready", rdy[0], 1);
        clearStats();
        sendStream(24, 1'b1, 1'b0);
        waitDrain();
        checkOutput("midreset_valid_count", valid_cnt[1], 48);

        $display("[TB] enable low mid-stream");
        sendStream(34, 1'b1, 1'b0);
        @(negedge Clk);
        Data       = 1'b1;
        Data_valid = 1'b1;
        En         = 1'b0;
        #1;
        checkOutput("ready_while_disabled", rdy[0], 0);
        @(posedge Clk);
        #1;
        modelReset();
        checkCleared("disable");
        En         = 1'b1;
        Data_valid = 1'b0;
        #1;
        checkOutput("disable_ready_after", rdy[0], 1);
        clearStats();
        sendStream(24, 1'b1, 1'b0);
        waitDrain();
        checkOutput("disable_valid_count", valid_cnt[1], 48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
